// File: rtl/modbus_frame_rx.sv
// modbus_frame_rx: Modbus RTU slave frame receiver; define MODBUS_CRC_CHECK_EN to build and check the CRC-16
module modbus_frame_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic [7:0]  dev_addr,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  rx_func,
    output logic [15:0] rx_reg_addr,
    output logic [15:0] rx_reg_data
);
    localparam int T35_CYCLES = (CLK_FREQ / BAUD_RATE) * 39;
    localparam int CW = $clog2(T35_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CLOSE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        num_q, num_d;
    logic              ovf_q, ovf_d;
    logic [5:0][7:0]   buf_q, buf_d;
    logic              fv_q, fv_d;
    logic              fe_q, fe_d;
    logic [7:0]        func_q, func_d;
    logic [15:0]       ra_q, ra_d;
    logic [15:0]       rd_q, rd_d;
    logic              crc_ok;

`ifdef MODBUS_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // A byte outside RECV opens a frame, so the CRC restarts from the preset
    always_comb crc_d = !rx_done ? crc_q : crc_upd((state_q == RECV) ? crc_q : 16'hFFFF, rx_data);

    // CRC accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= 16'hFFFF;
        else        crc_q <= crc_d;
    end

    assign crc_ok = (crc_q == 16'h0000);
`else
    assign crc_ok = 1'b1;
`endif

    // Frame assembly, silence timing and close-time evaluation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        buf_d   = buf_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        func_d  = func_q;
        ra_d    = ra_q;
        rd_d    = rd_q;
        if (state_q == CLOSE && buf_q[0] == dev_addr) begin
            if (num_q == 4'd8 && !ovf_q && crc_ok) begin
                fv_d   = 1'b1;
                func_d = buf_q[1];
                ra_d   = {buf_q[2], buf_q[3]};
                rd_d   = {buf_q[4], buf_q[5]};
            end else begin
                fe_d = 1'b1;
            end
        end
        if (state_q != RECV) begin
            state_d = rx_done ? RECV : IDLE;
            if (rx_done) begin
                cnt_d    = '0;
                num_d    = 4'd1;
                ovf_d    = 1'b0;
                buf_d[0] = rx_data;
            end
        end else if (rx_done) begin
            cnt_d = '0;
            num_d = (num_q == 4'd9) ? num_q : num_q + 4'd1;
            if (num_q < 4'd6) buf_d[num_q[2:0]] = rx_data;
            if (num_q > 4'd7) ovf_d = 1'b1;
        end else if (cnt_q == CW'(T35_CYCLES)) begin
            state_d = CLOSE;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State, frame store and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
            buf_q   <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            func_q  <= '0;
            ra_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
            buf_q   <= buf_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            func_q  <= func_d;
            ra_q    <= ra_d;
            rd_q    <= rd_d;
        end
    end

    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign rx_func     = func_q;
    assign rx_reg_addr = ra_q;
    assign rx_reg_data = rd_q;
endmodule
